// File: rtl/ps2kbd_pkg.sv
// Shared scan-code constants, FSM encoding and event bundle
// for the PS/2 keyboard event sequencer.
package ps2kbd_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] LSHIFT  = 8'h12;
    localparam logic [7:0] RSHIFT  = 8'h59;
    localparam logic [7:0] LCTRL   = 8'h14;
    localparam logic [7:0] CAPS    = 8'h58;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EMIT   = 2'd2
    } state_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2kbd_event_sequencer_if.sv
// FIFO pop handshake plus downstream key-event handshake
// and modifier/counter status of the sequencer.
interface ps2kbd_event_sequencer_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       fifo_data;
    logic             fifo_ready;
    logic             fifo_nextdata_n;
    logic             evt_valid;
    logic             evt_ready;
    logic [7:0]       evt_code;
    logic             evt_ext;
    logic             evt_break;
    logic             evt_repeat;
    logic             shift;
    logic             ctrl;
    logic             caps;
    logic [CNT_W-1:0] key_count;

    modport master (
        input  fifo_data, fifo_ready, evt_ready,
        output fifo_nextdata_n, evt_valid, evt_code, evt_ext,
        output evt_break, evt_repeat, shift, ctrl, caps, key_count
    );

    modport slave (
        output fifo_data, fifo_ready, evt_ready,
        input  fifo_nextdata_n, evt_valid, evt_code, evt_ext,
        input  evt_break, evt_repeat, shift, ctrl, caps, key_count
    );
endinterface

// File: rtl/ps2kbd_mod_tracker.sv
// Shift/ctrl/caps-lock state, updated once per decoded
// non-prefix byte; typematic repeats leave it untouched.
module ps2kbd_mod_tracker
    import ps2kbd_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       stb_i,
    input  logic [7:0] code_i,
    input  logic       ext_i,
    input  logic       brk_i,
    input  logic       rpt_i,
    output logic       shift_o,
    output logic       ctrl_o,
    output logic       caps_o
);

    logic lsh_q, rsh_q, lctl_q, rctl_q, caps_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lsh_q  <= 1'b0;
            rsh_q  <= 1'b0;
            lctl_q <= 1'b0;
            rctl_q <= 1'b0;
            caps_q <= 1'b0;
        end else if (stb_i && !rpt_i) begin
            if (!ext_i && code_i == LSHIFT) lsh_q <= !brk_i;
            if (!ext_i && code_i == RSHIFT) rsh_q <= !brk_i;
            // E0 14 is the right-hand ctrl key
            if (code_i == LCTRL) begin
                if (ext_i) rctl_q <= !brk_i;
                else       lctl_q <= !brk_i;
            end
            if (code_i == CAPS && !brk_i) caps_q <= !caps_q;
        end
    end

    assign shift_o = lsh_q | rsh_q;
    assign ctrl_o  = lctl_q | rctl_q;
    assign caps_o  = caps_q;

endmodule

// File: rtl/ps2kbd_event_sequencer.sv
// Pops PS/2 FIFO bytes, folds E0/F0 prefixes into one key
// event per key action and hands it on with valid/ready.
module ps2kbd_event_sequencer
    import ps2kbd_pkg::*;
#(
    parameter int CNT_W           = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input logic                       clk,
    input logic                       clrn,
    ps2kbd_event_sequencer_if.master  bus
);

    state_e           state_q;
    logic [7:0]       byte_q;
    logic             ext_q, brk_q;
    logic [7:0]       held_q;
    logic             held_ext_q, held_v_q;
    logic             nd_q, vld_q;
    logic [7:0]       code_q;
    logic             e_ext_q, e_brk_q, e_rpt_q;
    logic [CNT_W-1:0] cnt_q;

    logic held_hit, rpt_w, key_stb;

    assign held_hit = held_v_q && (held_q == byte_q) && (held_ext_q == ext_q);
    assign rpt_w    = !brk_q && held_hit;
    assign key_stb  = (state_q == DECODE) && !is_prefix(byte_q);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= FETCH;
            byte_q     <= 8'h00;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            held_q     <= 8'h00;
            held_ext_q <= 1'b0;
            held_v_q   <= 1'b0;
            nd_q       <= 1'b1;
            vld_q      <= 1'b0;
            code_q     <= 8'h00;
            e_ext_q    <= 1'b0;
            e_brk_q    <= 1'b0;
            e_rpt_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.fifo_ready) begin
                        byte_q  <= bus.fifo_data;
                        nd_q    <= 1'b0;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    nd_q    <= 1'b1;
                    state_q <= FETCH;
                    if (byte_q == PS2_EXT) begin
                        ext_q <= 1'b1;
                    end else if (byte_q == PS2_BRK) begin
                        brk_q <= 1'b1;
                    end else begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        if (!brk_q && !rpt_w) begin
                            held_q     <= byte_q;
                            held_ext_q <= ext_q;
                            held_v_q   <= 1'b1;
                        end else if (brk_q && held_hit) begin
                            held_v_q <= 1'b0;
                        end
                        // A suppressed repeat produces no event at all
                        if (!(rpt_w && SUPPRESS_REPEAT)) begin
                            vld_q   <= 1'b1;
                            code_q  <= byte_q;
                            e_ext_q <= ext_q;
                            e_brk_q <= brk_q;
                            e_rpt_q <= rpt_w;
                            state_q <= EMIT;
                            if (!brk_q && !rpt_w && cnt_q != '1)
                                cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (bus.evt_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    ps2kbd_mod_tracker u_mods (
        .clk     (clk),
        .clrn    (clrn),
        .stb_i   (key_stb),
        .code_i  (byte_q),
        .ext_i   (ext_q),
        .brk_i   (brk_q),
        .rpt_i   (rpt_w),
        .shift_o (bus.shift),
        .ctrl_o  (bus.ctrl),
        .caps_o  (bus.caps)
    );

    assign bus.fifo_nextdata_n = nd_q;
    assign bus.evt_valid       = vld_q;
    assign bus.evt_code        = code_q;
    assign bus.evt_ext         = e_ext_q;
    assign bus.evt_break       = e_brk_q;
    assign bus.evt_repeat      = e_rpt_q;
    assign bus.key_count       = cnt_q;

endmodule
